// File: rtl/multi_channel_trigger_capture.sv
// Multi-channel trigger capture engine.
// Each channel's samples go into a circular buffer. A level/edge trigger on a
// selectable channel, or an auto-trigger timeout, freezes a frame that holds
// pretrig samples before the trigger. The display side reads that frame by
// trigger-relative index.
// Ports:
//   CLOCK_50, reset          clock, async active-high reset
//   sample_valid/sample_data new sample set, channel c at [c*SAMPLE_W +: SAMPLE_W]
//   arm                      start/restart acquisition (latches trigger setup)
//   auto_en, edge_sel        auto-trigger enable, 0=rising 1=falling
//   trig_ch, trig_level      trigger source channel and threshold
//   pretrig                  samples kept before trigger
//   rd_ch, rd_addr, rd_data  trigger-relative frame read, 1-clock latency
//   frame_ready, auto_fired  frozen frame available / frame was force-triggered
//   busy                     acquisition in progress
module multi_channel_trigger_capture #(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned SAMPLE_W     = 12,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned AUTO_TIMEOUT = 5000000
) (
  input  logic                                             CLOCK_50,
  input  logic                                             reset,
  input  logic                                             sample_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0]                     sample_data,
  input  logic                                             arm,
  input  logic                                             auto_en,
  input  logic                                             edge_sel,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] trig_ch,
  input  logic [SAMPLE_W-1:0]                              trig_level,
  input  logic [ADDR_W-1:0]                                pretrig,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] rd_ch,
  input  logic [ADDR_W-1:0]                                rd_addr,
  output logic [SAMPLE_W-1:0]                              rd_data,
  output logic                                             frame_ready,
  output logic                                             auto_fired,
  output logic                                             busy
);

  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned TO_W   = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(AUTO_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, PRE_FILL, ARMED, POST, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   pre_cnt;
  logic [ADDR_W-1:0]   post_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic                prev_valid;
  logic [SAMPLE_W-1:0] prev_s;
  logic [ADDR_W-1:0]   pretrig_l;
  logic [CH_W-1:0]     trig_ch_l;
  logic                edge_l;
  logic [SAMPLE_W-1:0] level_l;
  logic [ADDR_W-1:0]   start_addr;

  logic [SAMPLE_W-1:0] mem [CHANNELS][DEPTH];

  logic                wr_en;
  logic [SAMPLE_W-1:0] trig_s;
  logic                level_hit;
  logic                auto_due;
  logic                trig_now;
  logic [ADDR_W-1:0]   post_target;
  logic [ADDR_W-1:0]   rd_idx;
  logic [SAMPLE_W-1:0] rd_mux;

  always_comb begin
    // A sample arriving together with arm is dropped.
    wr_en = sample_valid && !arm &&
            (state == PRE_FILL || state == ARMED || state == POST);

    trig_s = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (trig_ch_l == CH_W'(c)) trig_s = sample_data[c*SAMPLE_W +: SAMPLE_W];
    end

    if (edge_l) level_hit = prev_valid && (prev_s > level_l) && (trig_s <= level_l);
    else        level_hit = prev_valid && (prev_s < level_l) && (trig_s >= level_l);

    auto_due = auto_en && (to_cnt == TO_MAX);
    trig_now = (state == ARMED) && wr_en && (level_hit || auto_due);

    // DEPTH-1-pretrig_l in ADDR_W bits is just the complement.
    post_target = ~pretrig_l;

    rd_idx = start_addr + rd_addr;
    rd_mux = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (rd_ch == CH_W'(c)) rd_mux = mem[c][rd_idx];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        mem[c][wr_ptr] <= sample_data[c*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_mux;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      to_cnt      <= '0;
      prev_valid  <= 1'b0;
      prev_s      <= '0;
      pretrig_l   <= '0;
      trig_ch_l   <= '0;
      edge_l      <= 1'b0;
      level_l     <= '0;
      start_addr  <= '0;
      frame_ready <= 1'b0;
      auto_fired  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        prev_s     <= trig_s;
        prev_valid <= 1'b1;
      end

      if (arm) begin
        state       <= PRE_FILL;
        pretrig_l   <= pretrig;
        trig_ch_l   <= trig_ch;
        edge_l      <= edge_sel;
        level_l     <= trig_level;
        pre_cnt     <= '0;
        post_cnt    <= '0;
        to_cnt      <= '0;
        prev_valid  <= 1'b0;
        frame_ready <= 1'b0;
        auto_fired  <= 1'b0;
        busy        <= 1'b1;
      end else begin
        case (state)
          PRE_FILL: begin
            if (pretrig_l == '0) begin
              state <= ARMED;
            end else if (wr_en) begin
              pre_cnt <= pre_cnt + ADDR_W'(1);
              if (pre_cnt + ADDR_W'(1) == pretrig_l) state <= ARMED;
            end
          end
          ARMED: begin
            if (!auto_en)             to_cnt <= '0;
            else if (to_cnt != TO_MAX) to_cnt <= to_cnt + TO_W'(1);
            if (trig_now) begin
              start_addr <= wr_ptr - pretrig_l;
              auto_fired <= !level_hit;
              post_cnt   <= '0;
              if (post_target == '0) begin
                state       <= DONE;
                frame_ready <= 1'b1;
                busy        <= 1'b0;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            if (wr_en) begin
              post_cnt <= post_cnt + ADDR_W'(1);
              if (post_cnt + ADDR_W'(1) == post_target) begin
                state       <= DONE;
                frame_ready <= 1'b1;
                busy        <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_trigger_capture.sv
`timescale 1ns/1ps
module tb_multi_channel_trigger_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_data = '0;
  logic        arm = 1'b0;
  logic        auto_en = 1'b0;
  logic        edge_sel = 1'b0;
  logic [0:0]  trig_ch = '0;
  logic [11:0] trig_level = '0;
  logic [9:0]  pretrig = '0;
  logic [0:0]  rd_ch = '0;
  logic [9:0]  rd_addr = '0;
  logic [11:0] rd_data;
  logic        frame_ready;
  logic        auto_fired;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  multi_channel_trigger_capture #(
    .CHANNELS(2),
    .SAMPLE_W(12),
    .ADDR_W(10),
    .AUTO_TIMEOUT(16)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .arm(arm),
    .auto_en(auto_en),
    .edge_sel(edge_sel),
    .trig_ch(trig_ch),
    .trig_level(trig_level),
    .pretrig(pretrig),
    .rd_ch(rd_ch),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .frame_ready(frame_ready),
    .auto_fired(auto_fired),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus tasks are entered and left at a falling edge.
  task automatic strobe(input logic [11:0] c0, input logic [11:0] c1);
    sample_valid = 1'b1;
    sample_data  = {c1, c0};
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [9:0] pt, input logic ch, input logic es,
                        input logic [11:0] lvl, input logic ae);
    pretrig    = pt;
    trig_ch    = ch;
    edge_sel   = es;
    trig_level = lvl;
    auto_en    = ae;
    arm        = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic rd(input logic ch, input logic [9:0] a, output logic [11:0] d);
    rd_ch   = ch;
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL reset_frame_ready: got %b want 0", frame_ready); end
    n_cmp++; if (auto_fired !== 1'b0) begin n_bad++; $display("FAIL reset_auto_fired: got %b want 0", auto_fired); end
    n_cmp++; if (rd_data !== 12'd0) begin n_bad++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
    strobe(12'd5, 12'd5);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_strobe_busy: got %b want 0", busy); end
  endtask

  task automatic test_rising;
    logic [11:0] d;
    do_arm(10'd100, 1'b0, 1'b0, 12'd2048, 1'b0);
    for (int k = 0; k < 1179; k++) strobe(12'((8 * k) % 4096), 12'd0);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL rise_early_ready: got %b want 0", frame_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rise_busy: got %b want 1", busy); end
    strobe(12'((8 * 1179) % 4096), 12'd0);
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL rise_ready: got %b want 1", frame_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rise_done_busy: got %b want 0", busy); end
    n_cmp++; if (auto_fired !== 1'b0) begin n_bad++; $display("FAIL rise_auto_fired: got %b want 0", auto_fired); end
    rd(1'b0, 10'd100, d);
    n_cmp++; if (d !== 12'd2048) begin n_bad++; $display("FAIL rise_idx100: got %0d want 2048", d); end
    rd(1'b0, 10'd99, d);
    n_cmp++; if (d !== 12'd2040) begin n_bad++; $display("FAIL rise_idx99: got %0d want 2040", d); end
    rd(1'b0, 10'd0, d);
    n_cmp++; if (d !== 12'd1248) begin n_bad++; $display("FAIL rise_idx0: got %0d want 1248", d); end
    rd(1'b0, 10'd1023, d);
    n_cmp++; if (d !== 12'd1240) begin n_bad++; $display("FAIL rise_idx1023: got %0d want 1240", d); end
  endtask

  task automatic test_falling;
    logic [11:0] d;
    do_arm(10'd8, 1'b1, 1'b1, 12'd1000, 1'b0);
    repeat (8) strobe(12'd0, 12'd2000);
    strobe(12'd0, 12'd1500);
    strobe(12'd0, 12'd1008);
    strobe(12'd0, 12'd1000);
    repeat (1015) strobe(12'd0, 12'd3000);
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL fall_ready: got %b want 1", frame_ready); end
    n_cmp++; if (auto_fired !== 1'b0) begin n_bad++; $display("FAIL fall_auto_fired: got %b want 0", auto_fired); end
    rd(1'b1, 10'd8, d);
    n_cmp++; if (d !== 12'd1000) begin n_bad++; $display("FAIL fall_ch1_idx8: got %0d want 1000", d); end
    rd(1'b1, 10'd7, d);
    n_cmp++; if (d !== 12'd1008) begin n_bad++; $display("FAIL fall_ch1_idx7: got %0d want 1008", d); end
    rd(1'b1, 10'd0, d);
    n_cmp++; if (d !== 12'd2000) begin n_bad++; $display("FAIL fall_ch1_idx0: got %0d want 2000", d); end
    rd(1'b1, 10'd9, d);
    n_cmp++; if (d !== 12'd3000) begin n_bad++; $display("FAIL fall_ch1_idx9: got %0d want 3000", d); end
    rd(1'b0, 10'd8, d);
    n_cmp++; if (d !== 12'd0) begin n_bad++; $display("FAIL fall_ch0_idx8: got %0d want 0", d); end
  endtask

  task automatic test_auto;
    logic [11:0] d;
    do_arm(10'd0, 1'b0, 1'b0, 12'd2048, 1'b1);
    strobe(12'd500, 12'd1);
    strobe(12'd500, 12'd2);
    strobe(12'd500, 12'd3);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL auto_busy_before_timeout: got %b want 1", busy); end
    repeat (30) @(negedge clk);
    for (int k = 0; k < 1024; k++) strobe(12'd500, 12'(100 + k));
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL auto_ready: got %b want 1", frame_ready); end
    n_cmp++; if (auto_fired !== 1'b1) begin n_bad++; $display("FAIL auto_fired: got %b want 1", auto_fired); end
    rd(1'b1, 10'd0, d);
    n_cmp++; if (d !== 12'd100) begin n_bad++; $display("FAIL auto_trig_marker: got %0d want 100", d); end
    rd(1'b1, 10'd1, d);
    n_cmp++; if (d !== 12'd101) begin n_bad++; $display("FAIL auto_idx1_marker: got %0d want 101", d); end
    rd(1'b0, 10'd0, d);
    n_cmp++; if (d !== 12'd500) begin n_bad++; $display("FAIL auto_ch0_idx0: got %0d want 500", d); end
    auto_en = 1'b0;
  endtask

  task automatic test_wrap;
    logic [11:0] d;
    logic [11:0] exp_v;
    do_arm(10'd0, 1'b0, 1'b0, 12'd2048, 1'b0);
    for (int k = 0; k < 1500; k++) strobe(12'd0, 12'(k));
    for (int k = 1500; k < 2524; k++) strobe(12'd3000, 12'(k));
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_ready: got %b want 1", frame_ready); end
    rd(1'b0, 10'd0, d);
    n_cmp++; if (d !== 12'd3000) begin n_bad++; $display("FAIL wrap_ch0_idx0: got %0d want 3000", d); end
    for (int i = 0; i < 1024; i++) begin
      rd(1'b1, 10'(i), d);
      exp_v = 12'(1500 + i);
      n_cmp++;
      if (d !== exp_v) begin n_bad++; $display("FAIL wrap_idx%0d: got %0d want %0d", i, d, exp_v); end
    end
  endtask

  task automatic test_rearm;
    logic [11:0] d;
    do_arm(10'd4, 1'b0, 1'b0, 12'd2048, 1'b0);
    repeat (4) strobe(12'd0, 12'h0AA);
    strobe(12'd3000, 12'h0BB);
    repeat (10) strobe(12'd3000, 12'h0CC);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rearm_post_busy: got %b want 1", busy); end
    do_arm(10'd4, 1'b0, 1'b0, 12'd2048, 1'b0);
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL rearm_ready: got %b want 0", frame_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rearm_busy: got %b want 1", busy); end
    for (int k = 0; k < 4; k++) strobe(12'd0, 12'(12'h1F0 + k));
    strobe(12'd3000, 12'h200);
    for (int k = 1; k < 1019; k++) strobe(12'd3000, 12'(12'h200 + k));
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL rearm_early_ready: got %b want 0", frame_ready); end
    strobe(12'd3000, 12'(12'h200 + 1019));
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL rearm_ready_final: got %b want 1", frame_ready); end
    rd(1'b1, 10'd4, d);
    n_cmp++; if (d !== 12'h200) begin n_bad++; $display("FAIL rearm_trig_marker: got %0h want 200", d); end
    rd(1'b1, 10'd3, d);
    n_cmp++; if (d !== 12'h1F3) begin n_bad++; $display("FAIL rearm_pre_marker: got %0h want 1f3", d); end
    rd(1'b1, 10'd1023, d);
    n_cmp++; if (d !== 12'h5FB) begin n_bad++; $display("FAIL rearm_last_marker: got %0h want 5fb", d); end
    rd(1'b1, 10'd4, d);
  endtask

  task automatic test_async_reset;
    logic [11:0] d;
    do_arm(10'd0, 1'b0, 1'b0, 12'd2048, 1'b0);
    repeat (3) strobe(12'd0, 12'h0EE);
    n_cmp++; if (rd_data !== 12'h200) begin n_bad++; $display("FAIL areset_pre_rd: got %0h want 200", rd_data); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL areset_pre_busy: got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL areset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL areset_ready: got %b want 0", frame_ready); end
    n_cmp++; if (rd_data !== 12'd0) begin n_bad++; $display("FAIL areset_rd: got %0d want 0", rd_data); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_arm(10'd0, 1'b0, 1'b0, 12'd2048, 1'b0);
    strobe(12'd0, 12'h300);
    for (int k = 1; k < 1025; k++) strobe(12'd3000, 12'(12'h300 + k));
    n_cmp++; if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL areset_cap_ready: got %b want 1", frame_ready); end
    rd(1'b1, 10'd0, d);
    n_cmp++; if (d !== 12'h301) begin n_bad++; $display("FAIL areset_cap_idx0: got %0h want 301", d); end
    rd(1'b1, 10'd1023, d);
    n_cmp++; if (d !== 12'h700) begin n_bad++; $display("FAIL areset_cap_idx1023: got %0h want 700", d); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_rising();
    test_falling();
    test_auto();
    test_wrap();
    test_rearm();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
